// File: rtl/jtag_scan_master.sv
`default_nettype none
// ============================================================================
// Module   : jtag_scan_master
// Function : Runs IR/DR scans on a JTAG TAP starting and ending in Run-Test/Idle.
// Config   : define JTAG_SCAN_MASTER_TAP_RESET_EN for a power-on TAP reset.
// Revision : 1.0
// ============================================================================
module jtag_scan_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_ir,
  input  logic [5:0]  req_len,
  input  logic [39:0] req_data,
  output logic        resp_valid,
  output logic [39:0] resp_data,
  output logic        jtag_TCK,
  output logic        jtag_TMS,
  output logic        jtag_TDI,
  input  logic        jtag_TDO
);

  localparam logic [8:0] c_half_m1 = 9'(CLK_DIV - 1);
  localparam logic [8:0] c_full_m1 = 9'(2 * CLK_DIV - 1);
  localparam logic [5:0] c_max_len = 6'd40;
  localparam logic [5:0] c_tap_rst_last = 6'd7;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    SEL_DR      = 4'd1,
    SEL_IR      = 4'd2,
    CAPTURE     = 4'd3,
    SHIFT_ENTRY = 4'd4,
    SHIFT       = 4'd5,
    UPDATE      = 4'd6,
    RUN_IDLE    = 4'd7,
    RST_TAP     = 4'd8
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [8:0]  r_div_cnt;
  logic [5:0]  r_bit;
  logic [5:0]  w_bit_nxt;
  logic [5:0]  r_len;
  logic [5:0]  w_len_eff;
  logic        r_is_ir;
  logic [39:0] r_data;
  logic [39:0] r_cap;
  logic [39:0] r_resp_data;
  logic        r_resp_valid;
  logic        r_ready;
  logic        r_tck;
  logic        r_tms;
  logic        r_tdi;
  logic        r_tap_mode;
  logic        w_tap_pend;
  logic        w_half_end;
  logic        w_period_end;
  logic        w_last_bit;
  logic        w_accept;
  logic        w_done;
  logic        w_start_tap;
  logic        w_tms_nxt;
  logic        w_tdi_nxt;

`ifdef JTAG_SCAN_MASTER_TAP_RESET_EN
  // Set by reset so the first cycle out of reset launches the TAP reset walk.
  logic r_tap_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tap_pend <= 1'b1;
    end else if (w_start_tap) begin
      r_tap_pend <= 1'b0;
    end
  end

  assign w_tap_pend = r_tap_pend;
`else
  assign w_tap_pend = 1'b0;
`endif

  assign w_half_end   = (r_div_cnt == c_half_m1);
  assign w_period_end = (r_div_cnt == c_full_m1);
  assign w_last_bit   = (r_bit == (r_len - 6'd1));

  assign w_len_eff = (req_len == 6'd0)     ? 6'd1 :
                     (req_len > c_max_len) ? c_max_len : req_len;

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_start_tap = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tap_pend) begin
          w_state_nxt = RST_TAP;
          w_bit_nxt   = 6'd0;
          w_start_tap = 1'b1;
        end else if (req_valid && r_ready) begin
          w_state_nxt = SEL_DR;
          w_bit_nxt   = 6'd0;
          w_accept    = 1'b1;
        end
      end
      SEL_DR: begin
        if (w_period_end) w_state_nxt = r_is_ir ? SEL_IR : CAPTURE;
      end
      SEL_IR: begin
        if (w_period_end) w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (w_period_end) w_state_nxt = SHIFT_ENTRY;
      end
      SHIFT_ENTRY: begin
        if (w_period_end) begin
          w_state_nxt = SHIFT;
          w_bit_nxt   = 6'd0;
        end
      end
      SHIFT: begin
        if (w_period_end) begin
          if (w_last_bit) w_state_nxt = UPDATE;
          else            w_bit_nxt   = r_bit + 6'd1;
        end
      end
      UPDATE: begin
        if (w_period_end) w_state_nxt = RUN_IDLE;
      end
      RUN_IDLE: begin
        if (w_period_end) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      RST_TAP: begin
        if (w_period_end) begin
          if (r_bit == c_tap_rst_last) w_state_nxt = RUN_IDLE;
          else                         w_bit_nxt   = r_bit + 6'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // TMS/TDI are registered from the next state so they only move as TCK falls.
  always_comb begin
    w_tms_nxt = 1'b1;
    w_tdi_nxt = 1'b1;
    case (w_state_nxt)
      CAPTURE, SHIFT_ENTRY, RUN_IDLE: w_tms_nxt = 1'b0;
      SHIFT: begin
        w_tms_nxt = (w_bit_nxt == (r_len - 6'd1));
        w_tdi_nxt = r_data[w_bit_nxt];
      end
      default: w_tms_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_div_cnt    <= 9'd0;
      r_bit        <= 6'd0;
      r_len        <= 6'd0;
      r_is_ir      <= 1'b0;
      r_data       <= 40'd0;
      r_cap        <= 40'd0;
      r_resp_data  <= 40'd0;
      r_resp_valid <= 1'b0;
      r_ready      <= 1'b0;
      r_tck        <= 1'b0;
      r_tms        <= 1'b1;
      r_tdi        <= 1'b1;
      r_tap_mode   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit        <= w_bit_nxt;
      r_tms        <= w_tms_nxt;
      r_tdi        <= w_tdi_nxt;
      r_resp_valid <= w_done && !r_tap_mode;
      r_ready      <= (w_state_nxt == IDLE) && !(w_done && !r_tap_mode);

      if (r_state == IDLE) begin
        r_div_cnt <= 9'd0;
        r_tck     <= 1'b0;
      end else begin
        r_div_cnt <= w_period_end ? 9'd0 : r_div_cnt + 9'd1;
        if (w_half_end)        r_tck <= 1'b1;
        else if (w_period_end) r_tck <= 1'b0;
      end

      if (w_accept) begin
        r_len   <= w_len_eff;
        r_is_ir <= req_is_ir;
        r_data  <= req_data;
        r_cap   <= 40'd0;
      end

      // TDO is taken on the same edge that raises TCK.
      if ((r_state == SHIFT) && w_half_end) begin
        r_cap[r_bit] <= jtag_TDO;
      end

      if (w_done && !r_tap_mode) begin
        r_resp_data <= r_cap;
      end

      if (w_start_tap) begin
        r_tap_mode <= 1'b1;
      end else if (w_done) begin
        r_tap_mode <= 1'b0;
      end
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign jtag_TCK   = r_tck;
  assign jtag_TMS   = r_tms;
  assign jtag_TDI   = r_tdi;

endmodule
`default_nettype wire

// File: tb/tb_jtag_scan_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_scan_master
// Function : Self-checking bench for jtag_scan_master with a response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_jtag_scan_master;

  localparam int CLK_DIV = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_ir;
  logic [5:0]  req_len;
  logic [39:0] req_data;
  logic        resp_valid;
  logic [39:0] resp_data;
  logic        jtag_TCK;
  logic        jtag_TMS;
  logic        jtag_TDI;
  logic        jtag_TDO;

  int errors = 0;
  int checks = 0;

  bit          tdo_loop  = 1'b0;
  bit          tdo_const = 1'b0;
  logic        lb_q      = 1'b1;
  bit          tms_log[$];
  bit          tdi_log[$];
  logic [39:0] exp_q[$];

  jtag_scan_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_is_ir  (req_is_ir),
    .req_len    (req_len),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .jtag_TCK   (jtag_TCK),
    .jtag_TMS   (jtag_TMS),
    .jtag_TDI   (jtag_TDI),
    .jtag_TDO   (jtag_TDO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target model: records TMS/TDI per TCK period; loopback delays TDI by one TCK.
  always @(posedge jtag_TCK) begin
    tms_log.push_back(jtag_TMS);
    tdi_log.push_back(jtag_TDI);
    lb_q <= jtag_TDI;
  end

  assign jtag_TDO = tdo_loop ? lb_q : tdo_const;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout need $finish");
    $fatal(1);
  end

  function automatic int eff_len(input logic [5:0] len);
    if (len == 6'd0) return 1;
    if (len > 6'd40) return 40;
    return int'(len);
  endfunction

  function automatic logic [39:0] model_resp(input logic [39:0] data, input int eff);
    logic [39:0] r;
    r = '0;
    for (int k = 0; k < eff; k++) begin
      if (tdo_loop) r[k] = (k == 0) ? 1'b1 : data[k-1];
      else          r[k] = tdo_const;
    end
    return r;
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL %s: req_ready got 0 need 1 within 300 cycles", name);
    end
  endtask

  task automatic run_scan(input string name, input bit is_ir, input logic [5:0] len,
                          input logic [39:0] data);
    int          n;
    int          eff;
    int          bad;
    logic [39:0] exp;
    bit          exp_tms[$];
    bit          exp_tdi[$];

    eff = eff_len(len);
    wait_ready(name);
    if (!req_ready) return;

    tms_log.delete();
    tdi_log.delete();
    req_valid = 1'b1;
    req_is_ir = is_ir;
    req_len   = len;
    req_data  = data;
    exp_q.push_back(model_resp(data, eff));
    @(negedge clk);
    req_valid = 1'b0;
    req_is_ir = 1'b0;
    req_len   = 6'h3f;
    req_data  = '1;

    n = 0;
    while (!resp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!resp_valid) begin
      errors++;
      $display("FAIL %s: resp_valid got 0 need 1 within 2000 cycles", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end

    exp = exp_q.pop_front();
    checks++;
    if (resp_data !== exp) begin
      errors++;
      $display("FAIL %s resp_data: got %h need %h", name, resp_data, exp);
    end

    exp_tms.push_back(1'b1); exp_tdi.push_back(1'b1);
    if (is_ir) begin
      exp_tms.push_back(1'b1); exp_tdi.push_back(1'b1);
    end
    exp_tms.push_back(1'b0); exp_tdi.push_back(1'b1);
    exp_tms.push_back(1'b0); exp_tdi.push_back(1'b1);
    for (int k = 0; k < eff; k++) begin
      exp_tms.push_back(k == eff - 1);
      exp_tdi.push_back(data[k]);
    end
    exp_tms.push_back(1'b1); exp_tdi.push_back(1'b1);
    exp_tms.push_back(1'b0); exp_tdi.push_back(1'b1);

    checks++;
    if (tms_log.size() !== exp_tms.size()) begin
      errors++;
      $display("FAIL %s tck_periods: got %0d need %0d", name, tms_log.size(), exp_tms.size());
    end

    bad = 0;
    for (int i = 0; i < exp_tms.size() && i < tms_log.size(); i++) begin
      if (tms_log[i] !== exp_tms[i] || tdi_log[i] !== exp_tdi[i]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s tms_tdi_seq: got %0d wrong periods need 0", name, bad);
    end

    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s resp_pulse_width: resp_valid got %b need 0 on second cycle", name, resp_valid);
    end
    checks++;
    if (resp_data !== exp || jtag_TCK !== 1'b0) begin
      errors++;
      $display("FAIL %s hold/idle: resp_data got %h need %h, TCK got %b need 0",
               name, resp_data, exp, jtag_TCK);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (jtag_TCK !== 1'b0 || jtag_TMS !== 1'b1 || jtag_TDI !== 1'b1) begin
      errors++;
      $display("FAIL reset_pins: TCK/TMS/TDI got %b%b%b need 011", jtag_TCK, jtag_TMS, jtag_TDI);
    end
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: ready/resp_valid got %b%b need 00", req_ready, resp_valid);
    end
    checks++;
    if (resp_data !== 40'd0) begin
      errors++;
      $display("FAIL reset_resp_data: got %h need 0", resp_data);
    end
  endtask

  task automatic test_release();
    int n;
    bad_tms_check: begin end
    tms_log.delete();
    rst = 1'b0;
    @(negedge clk);
`ifdef JTAG_SCAN_MASTER_TAP_RESET_EN
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 36) begin
      errors++;
      $display("FAIL tap_reset_ready_delay: got %0d cycles need 36", n);
    end
    checks++;
    if (tms_log.size() !== 9) begin
      errors++;
      $display("FAIL tap_reset_pulses: got %0d need 9", tms_log.size());
    end else begin
      n = 0;
      for (int i = 0; i < 9; i++) if (tms_log[i] !== (i < 8)) n++;
      checks++;
      if (n != 0) begin
        errors++;
        $display("FAIL tap_reset_tms: got %0d wrong periods need 0", n);
      end
    end
`else
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b need 1", req_ready);
    end
    checks++;
    if (tms_log.size() !== 0) begin
      errors++;
      $display("FAIL no_tck_after_reset: got %0d pulses need 0", tms_log.size());
    end
`endif
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_resp_valid: got %b need 0", resp_valid);
    end
  endtask

  task automatic test_ir_scan();
    tdo_loop  = 1'b0;
    tdo_const = 1'b0;
    run_scan("ir_len5", 1'b1, 6'd5, 40'h11);
  endtask

  task automatic test_dr_loopback();
    tdo_loop = 1'b1;
    run_scan("dr_len40_loop", 1'b0, 6'd40, {6'h10, 32'h0, 2'b10});
    for (int i = 0; i < 3; i++) begin
      run_scan("rand_loop", 1'($urandom_range(0, 1)), 6'($urandom_range(1, 40)),
               {8'($urandom), 32'($urandom)});
    end
  endtask

  task automatic test_len_bounds();
    tdo_loop  = 1'b0;
    tdo_const = 1'b1;
    run_scan("dr_len0", 1'b0, 6'd0, 40'h0);
    run_scan("ir_len63", 1'b1, 6'd63, 40'h12_3456_789a);
    tdo_const = 1'b0;
    run_scan("dr_len1", 1'b0, 6'd1, 40'h1);
  endtask

  task automatic test_abort();
    int n;
    int pulses;
    tdo_loop = 1'b1;
    wait_ready("abort_start");
    tms_log.delete();
    req_valid = 1'b1;
    req_is_ir = 1'b0;
    req_len   = 6'd40;
    req_data  = 40'hff_0f0f_0f0f;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (tms_log.size() < 14 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tms_log.size() < 14) begin
      errors++;
      $display("FAIL abort_reach_bit10: got %0d periods need 14", tms_log.size());
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (jtag_TCK !== 1'b0 || jtag_TMS !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_pins: TCK/TMS/resp_valid got %b%b%b need 010",
               jtag_TCK, jtag_TMS, resp_valid);
    end
    rst = 1'b0;
    pulses = 0;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      if (resp_valid) pulses++;
      n++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_resp: got %0d resp pulses need 0", pulses);
    end
    run_scan("after_abort", 1'b1, 6'd9, 40'h1a5);
  endtask

  task automatic test_back_to_back();
    int          n;
    int          acc;
    int          nresp;
    int          acc_n[2];
    int          resp_n[2];
    bit          pend;
    bit          prev_resp;
    logic [39:0] exp;

    tdo_loop = 1'b1;
    wait_ready("b2b_start");
    req_valid = 1'b1;
    req_is_ir = 1'b0;
    req_len   = 6'd8;
    req_data  = 40'ha5;
    exp_q.push_back(model_resp(40'ha5, 8));
    exp_q.push_back(model_resp(40'h5c3, 12));
    acc = 0; nresp = 0; n = 0; pend = 0; prev_resp = 0;
    acc_n[0] = 0; acc_n[1] = 0; resp_n[0] = 0; resp_n[1] = 0;
    while (nresp < 2 && n < 3000) begin
      if (pend) begin
        acc++;
        pend = 0;
        if (acc == 1) begin
          req_is_ir = 1'b1;
          req_len   = 6'd12;
          req_data  = 40'h5c3;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (req_valid && req_ready && acc < 2) begin
        pend = 1;
        acc_n[acc] = n;
      end
      if (resp_valid) begin
        checks++;
        if (prev_resp) begin
          errors++;
          $display("FAIL b2b_pulse_width: resp_valid got 1 need 0 on consecutive cycle");
        end else begin
          if (nresp < 2) resp_n[nresp] = n;
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 40'hx;
          checks++;
          if (resp_data !== exp) begin
            errors++;
            $display("FAIL b2b_resp%0d: got %h need %h", nresp, resp_data, exp);
          end
          nresp++;
        end
      end
      prev_resp = resp_valid;
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    checks++;
    if (nresp !== 2 || acc !== 2) begin
      errors++;
      $display("FAIL b2b_counts: got %0d resp %0d accepts need 2 2", nresp, acc);
    end
    checks++;
    if (!(acc_n[1] > resp_n[0])) begin
      errors++;
      $display("FAIL b2b_order: second accept at %0d, first resp at %0d, need accept later",
               acc_n[1], resp_n[0]);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last_pulse: resp_valid got %b need 0", resp_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_is_ir = 1'b0;
    req_len   = 6'd0;
    req_data  = 40'd0;
    test_reset();
    test_release();
    test_ir_scan();
    test_dr_loopback();
    test_len_bounds();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per TCK half-period (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  scan request valid.
REQ-005 SHALL have port req_ready  output  1  master can accept a request.
REQ-006 SHALL have port req_is_ir  input  1  1 = IR scan, 0 = DR scan.
REQ-007 SHALL have port req_len  input  6  number of shift bits, 1..40.
REQ-008 SHALL have port req_data  input  40  TDI bits, LSB shifted first.
REQ-009 SHALL have port resp_valid  output  1  one-cycle pulse, scan complete.
REQ-010 SHALL have port resp_data  output  40  captured TDO bits.
REQ-011 SHALL have port jtag_TCK  output  1  test clock.
REQ-012 SHALL have port jtag_TMS  output  1  test mode select.
REQ-013 SHALL have port jtag_TDI  output  1  test data in.
REQ-014 SHALL have port jtag_TDO  input  1  test data out from target.

Function
REQ-015 SHALL accept a request on a clk edge with req_valid && req_ready, registering req_is_ir, req_len and req_data; req_ready SHALL be high only in state IDLE with no scan pending.
REQ-016 SHALL generate TCK as a square wave only while a scan or TAP reset runs: low CLK_DIV cycles, then high CLK_DIV cycles; TCK SHALL rest low when idle.
REQ-017 SHALL change TMS/TDI only while TCK is low (at start of each TCK period) and sample jtag_TDO on the clk edge that drives TCK high.
REQ-018 SHALL use FSM states IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT_ENTRY, SHIFT, UPDATE, RUN_IDLE, RST_TAP, one TCK period each except SHIFT (req_len periods) and RST_TAP.
REQ-019 TMS per period: SEL_DR=1, SEL_IR=1 (IR only; DR scan skips it), CAPTURE=0, SHIFT_ENTRY=0, SHIFT=0 except last bit =1, UPDATE=1, RUN_IDLE=0.
REQ-020 In SHIFT period k (k=0..req_len-1) TDI SHALL equal req_data[k]; TDO sampled in period k SHALL be stored at resp_data[k]; resp_data bits >= req_len SHALL be 0; TDI SHALL be 1 outside SHIFT.
REQ-021 Total TCK periods per scan SHALL be req_len+6 for IR and req_len+5 for DR.
REQ-022 resp_valid SHALL pulse for exactly one clk cycle on the cycle after the RUN_IDLE period ends; resp_data SHALL hold its value until the next resp_valid; FSM SHALL return to IDLE in that same cycle.
REQ-023 req_len = 0 SHALL be treated as 1; req_len > 40 SHALL be treated as 40.
REQ-024 req_valid while busy SHALL be ignored (no queueing); req_* SHALL be don't-care after acceptance.

Reset
REQ-025 On rst: state IDLE, jtag_TCK=0, jtag_TMS=1, jtag_TDI=1, req_ready=0 for the reset cycle, resp_valid=0, resp_data=0, all counters 0.
REQ-026 rst asserted mid-scan SHALL abort the scan on that edge with no resp_valid; the TAP state is then undefined unless REQ-028 applies.

Configuration
REQ-027 Macro JTAG_SCAN_MASTER_TAP_RESET_EN SHALL select power-on TAP reset.
REQ-028 With macro defined: after rst deasserts SHALL enter RST_TAP, emit 8 TCK periods with TMS=1 then 1 period TMS=0 (RUN_IDLE), then IDLE; req_ready low throughout; no resp_valid.
REQ-029 Without macro: after rst deasserts SHALL enter IDLE directly, req_ready=1 on next cycle, target TAP assumed in Run-Test/Idle.

Verification
REQ-030 CLK_DIV=2, macro defined, rst released -> exactly 9 TCK pulses, TMS=1 for first 8, req_ready rises after 36 clk cycles.
REQ-031 IR scan req_len=5, req_data=0x11, TDO tied 0 -> 11 TCK periods, TDI sequence 1,0,0,0,1 in SHIFT, TMS=1 on 5th shift bit, resp_data=0.
REQ-032 DR scan req_len=40, req_data={6'h10,32'h0,2'b10}, TDO looped to TDI delayed one TCK -> 45 TCK periods, resp_data[39:1]=req_data[38:0].
REQ-033 DR scan req_len=0, TDO=1 -> one shift bit with TMS=1, resp_data=0x1, 6 TCK periods total.
REQ-034 rst pulsed during SHIFT bit 10 of a 40-bit scan -> next cycle TCK=0, TMS=1, no resp_valid; following scan completes normally.
REQ-035 req_valid held high across two back-to-back scans -> second accepted only after first resp_valid, each resp_valid exactly one cycle.
